fpu_esc_sequencer: RTL and testbench
====================================

Name: fpu_esc_sequencer

Overview:
- Upstream feeder for the CPU-side FPU adapter.
- Accepts decoded ESC/WAIT instructions from the CPU execute stage along with the effective address.
- Issues the one-cycle escape/dispatch to the adapter.
- For memory operands, moves 16-bit words between system memory and the adapter: loads via memory reads then adapter writes; stores via adapter reads then memory writes.
- Reports completion back to the CPU microcode.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles waiting on any adapter or memory handshake before abort.
- TMO_W, 10: width of the watchdog counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- instr_valid  in  1  CPU presents instruction
- instr_opcode  in  8  opcode (D8-DF, 9B)
- instr_modrm  in  8  ModR/M byte
- instr_ea  in  20  effective address of memory operand
- instr_ready  out  1  sequencer can accept (IDLE only)
- instr_done  out  1  one-cycle completion pulse
- instr_err  out  1  qualifies instr_done: non-ESC opcode or timeout
- ax_we  out  1  one-cycle pulse, ax_data valid (FSTSW AX)
- ax_data  out  16  status word destined for AX
- adp_escape  out  1  one-cycle dispatch pulse to adapter
- adp_opcode  out  8  held opcode
- adp_modrm  out  8  held ModR/M
- adp_wr  out  1  one-cycle data word strobe to adapter
- adp_wdata  out  16  load data word
- adp_rd  out  1  request store word (level until adp_rvalid)
- adp_rvalid  in  1  adapter store word valid
- adp_rdata  in  16  store data word
- adp_ready  in  1  adapter idle/complete (its cpu_ready)
- mem_addr  out  20  memory address
- mem_rd  out  1  memory read request (level until mem_ack)
- mem_wr  out  1  memory write request (level until mem_ack)
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_ack  in  1  memory access complete

Behaviour:
- Reset (async, reset_n=0): all outputs 0 except instr_ready=1; state IDLE; word counter and watchdog cleared. Reset mid-operation abandons the transfer with no done pulse.
- Classification (mod = modrm[7:6], reg = modrm[5:3]):
  - Loads: D8 mod!=11 → 2 words; D9 /0 → 2; D9 /5 → 1; DD /0 → 4; DB /5 → 5.
  - Stores: D9 /2 → 2; D9 /7 → 1; DD /2 → 4; DD /7 → 1; DB /7 → 5.
  - DF with modrm E0 → AX store of 1 word.
  - Everything else in D8-DF or 9B → no transfer.
  - Other opcodes → error.
- IDLE: instr_ready=1. On instr_valid, latch opcode/modrm/ea and counts, drop instr_ready. If the opcode is not ESC/9B, go to DONE with err=1.
- DISPATCH: 1 cycle, adp_escape=1; adp_opcode/adp_modrm are held until the next accept. Next state is LD_MEM, ST_ADP, or WAIT_ADP according to class.
- LD_MEM: mem_rd=1, mem_addr = ea + 2*k. Address arithmetic is mod 2^20, so FFFFE+2 wraps to 00000. On mem_ack, capture mem_rdata and go to LD_PUSH.
- LD_PUSH: 1 cycle, adp_wr=1, adp_wdata = captured word; k++. If k == n go to WAIT_ADP, else go to LD_MEM. Word 0 is the least-significant word.
- ST_ADP: adp_rd=1 until adp_rvalid; capture adp_rdata. For the AX class, next is AX_WB, else ST_MEM.
- ST_MEM: mem_wr=1, mem_addr = ea + 2*k, mem_wdata = captured word. On mem_ack, k++. If k == n go to WAIT_ADP, else go to ST_ADP.
- AX_WB: 1 cycle, ax_we=1 with ax_data; then go to WAIT_ADP.
- WAIT_ADP: wait for adp_ready=1, with a minimum of 1 cycle in the state. Then go to DONE.
- DONE: 1 cycle, instr_done=1 (instr_err as set); then go to IDLE. instr_ready rises in the cycle after DONE. Latency with no operand and adp_ready=1 is: accept → escape → wait → done, i.e. 3 cycles.
- Watchdog: counts cycles while in LD_MEM, ST_ADP, ST_MEM or WAIT_ADP, and resets on every state change. When count reaches TIMEOUT_CYCLES, go to DONE with instr_err=1, deasserting mem_rd/mem_wr/adp_rd that same cycle.
- mem_ack is ignored outside LD_MEM/ST_MEM. adp_rvalid is ignored outside ST_ADP. mem_ack in the same cycle as the timeout expiry: the ack wins and the watchdog is ignored.
- instr_valid outside IDLE is ignored; the CPU holds it until ready.

Decomposition:
- Package fpu_esc_pkg: state encoding constants, opcode constants (ESC_D8..ESC_DF, OP_WAIT), class encoding (NONE/LOAD/STORE/AX/ERR).
- Sub-module fpu_esc_classify: combinational, opcode+modrm → {class, nwords[2:0]}. Reusable by the decode stage.

Test Plan:
- D9 /0, ea=01230, memory words 0000/3F80 → mem reads at 01230 and 01232; adp_wr twice with 0000 then 3F80; done after adp_ready; err=0.
- DD /2, ea=FFFFC, adapter returns 1111/2222/3333/4444 → mem writes at FFFFC, FFFFE, 00000, 00002 with those values.
- DF E0, adapter returns 3800 → ax_we pulse with ax_data=3800; no mem_rd/mem_wr ever asserted.
- D8 C1 (register form), adp_ready=1 → escape the cycle after accept, instr_done 2 cycles later, no transfers.
- DB /5 with mem_ack withheld, TIMEOUT_CYCLES=8 → mem_rd drops after 8 cycles; instr_done with instr_err=1; instr_ready returns.
- reset_n pulsed low during the third LD_MEM of DB /5 → all outputs at reset values immediately; next instruction (9B) completes normally.

Source files
------------

// File: rtl/fpu_esc_pkg.sv
// Shared types and constants for the FPU escape sequencer and its decode helper.
package fpu_esc_pkg;

  localparam logic [7:0] EscD8 = 8'hD8;
  localparam logic [7:0] EscD9 = 8'hD9;
  localparam logic [7:0] EscDA = 8'hDA;
  localparam logic [7:0] EscDB = 8'hDB;
  localparam logic [7:0] EscDC = 8'hDC;
  localparam logic [7:0] EscDD = 8'hDD;
  localparam logic [7:0] EscDE = 8'hDE;
  localparam logic [7:0] EscDF = 8'hDF;
  localparam logic [7:0] OpWait = 8'h9B;

  // ModR/M that turns DF into FSTSW AX rather than a register-form op.
  localparam logic [7:0] ModrmFstswAx = 8'hE0;

  typedef enum logic [2:0] {
    ClsNone,
    ClsLoad,
    ClsStore,
    ClsAx,
    ClsErr
  } esc_class_e;

  typedef enum logic [3:0] {
    StIdle,
    StDispatch,
    StLdMem,
    StLdPush,
    StStAdp,
    StStMem,
    StAxWb,
    StWaitAdp,
    StDone
  } esc_state_e;

  function automatic logic is_esc_op(logic [7:0] op);
    return op inside {EscD8, EscD9, EscDA, EscDB, EscDC, EscDD, EscDE, EscDF, OpWait};
  endfunction

endpackage

// File: rtl/fpu_esc_classify.sv
// Combinational decode of an ESC/WAIT instruction into transfer class and word count.
module fpu_esc_classify
  import fpu_esc_pkg::*;
(
  input  logic [7:0] opcode_i,
  input  logic [7:0] modrm_i,
  output esc_class_e cls_o,
  output logic [2:0] nwords_o
);

  logic       mem_form;
  logic [2:0] reg_f;

  assign mem_form = (modrm_i[7:6] != 2'b11);
  assign reg_f    = modrm_i[5:3];

  always_comb begin
    cls_o    = ClsNone;
    nwords_o = 3'd0;
    if (!is_esc_op(opcode_i)) begin
      cls_o = ClsErr;
    end else if (opcode_i == EscDF && modrm_i == ModrmFstswAx) begin
      cls_o    = ClsAx;
      nwords_o = 3'd1;
    end else if (mem_form) begin
      case (opcode_i)
        EscD8: begin
          cls_o    = ClsLoad;
          nwords_o = 3'd2;
        end
        EscD9: begin
          case (reg_f)
            3'd0: begin
              cls_o    = ClsLoad;
              nwords_o = 3'd2;
            end
            3'd5: begin
              cls_o    = ClsLoad;
              nwords_o = 3'd1;
            end
            3'd2: begin
              cls_o    = ClsStore;
              nwords_o = 3'd2;
            end
            3'd7: begin
              cls_o    = ClsStore;
              nwords_o = 3'd1;
            end
            default: ;
          endcase
        end
        EscDB: begin
          case (reg_f)
            3'd5: begin
              cls_o    = ClsLoad;
              nwords_o = 3'd5;
            end
            3'd7: begin
              cls_o    = ClsStore;
              nwords_o = 3'd5;
            end
            default: ;
          endcase
        end
        EscDD: begin
          case (reg_f)
            3'd0: begin
              cls_o    = ClsLoad;
              nwords_o = 3'd4;
            end
            3'd2: begin
              cls_o    = ClsStore;
              nwords_o = 3'd4;
            end
            3'd7: begin
              cls_o    = ClsStore;
              nwords_o = 3'd1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_esc_sequencer.sv
// Sequences ESC/WAIT instructions into adapter dispatch plus 16-bit operand moves
// between system memory and the FPU adapter, with a handshake watchdog.
module fpu_esc_sequencer
  import fpu_esc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TMO_W          = 10
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        instr_valid_i,
  input  logic [7:0]  instr_opcode_i,
  input  logic [7:0]  instr_modrm_i,
  input  logic [19:0] instr_ea_i,
  output logic        instr_ready_o,
  output logic        instr_done_o,
  output logic        instr_err_o,
  output logic        ax_we_o,
  output logic [15:0] ax_data_o,
  output logic        adp_escape_o,
  output logic [7:0]  adp_opcode_o,
  output logic [7:0]  adp_modrm_o,
  output logic        adp_wr_o,
  output logic [15:0] adp_wdata_o,
  output logic        adp_rd_o,
  input  logic        adp_rvalid_i,
  input  logic [15:0] adp_rdata_i,
  input  logic        adp_ready_i,
  output logic [19:0] mem_addr_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  esc_state_e       state_q, state_d;
  esc_class_e       cls_q, cls_d, cls_dec;
  logic [2:0]       nwords_q, nwords_d, nwords_dec;
  logic [2:0]       k_q, k_d, k_inc;
  logic [7:0]       op_q, op_d, modrm_q, modrm_d;
  logic [19:0]      ea_q, ea_d, word_addr;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expired, watched;

  fpu_esc_classify u_classify (
    .opcode_i (instr_opcode_i),
    .modrm_i  (instr_modrm_i),
    .cls_o    (cls_dec),
    .nwords_o (nwords_dec)
  );

  // Word k lives at ea + 2k; the 20-bit add wraps at the top of memory.
  assign word_addr   = ea_q + {16'd0, k_q, 1'b0};
  assign k_inc       = k_q + 3'd1;
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES));
  assign watched     = state_q inside {StLdMem, StStAdp, StStMem, StWaitAdp};

  assign ax_data_o    = data_q;
  assign adp_wdata_o  = data_q;
  assign mem_wdata_o  = data_q;
  assign adp_opcode_o = op_q;
  assign adp_modrm_o  = modrm_q;

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    nwords_d      = nwords_q;
    k_d           = k_q;
    op_d          = op_q;
    modrm_d       = modrm_q;
    ea_d          = ea_q;
    data_d        = data_q;
    err_d         = err_q;
    instr_ready_o = 1'b0;
    instr_done_o  = 1'b0;
    instr_err_o   = 1'b0;
    ax_we_o       = 1'b0;
    adp_escape_o  = 1'b0;
    adp_wr_o      = 1'b0;
    adp_rd_o      = 1'b0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = 1'b0;
    mem_addr_o    = 20'd0;

    unique case (state_q)
      StIdle: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          op_d     = instr_opcode_i;
          modrm_d  = instr_modrm_i;
          ea_d     = instr_ea_i;
          cls_d    = cls_dec;
          nwords_d = nwords_dec;
          k_d      = 3'd0;
          err_d    = (cls_dec == ClsErr);
          state_d  = (cls_dec == ClsErr) ? StDone : StDispatch;
        end
      end
      StDispatch: begin
        adp_escape_o = 1'b1;
        case (cls_q)
          ClsLoad:         state_d = StLdMem;
          ClsStore, ClsAx: state_d = StStAdp;
          default:         state_d = StWaitAdp;
        endcase
      end
      StLdMem: begin
        mem_rd_o   = !tmo_expired;
        mem_addr_o = word_addr;
        // A late ack still completes the word even when the watchdog fires.
        if (mem_ack_i) begin
          data_d  = mem_rdata_i;
          state_d = StLdPush;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StLdPush: begin
        adp_wr_o = 1'b1;
        k_d      = k_inc;
        state_d  = (k_inc == nwords_q) ? StWaitAdp : StLdMem;
      end
      StStAdp: begin
        adp_rd_o = !tmo_expired;
        if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (adp_rvalid_i) begin
          data_d  = adp_rdata_i;
          state_d = (cls_q == ClsAx) ? StAxWb : StStMem;
        end
      end
      StStMem: begin
        mem_wr_o   = !tmo_expired;
        mem_addr_o = word_addr;
        if (mem_ack_i) begin
          k_d     = k_inc;
          state_d = (k_inc == nwords_q) ? StWaitAdp : StStAdp;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StAxWb: begin
        ax_we_o = 1'b1;
        state_d = StWaitAdp;
      end
      StWaitAdp: begin
        if (adp_ready_i) begin
          state_d = StDone;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        instr_done_o = 1'b1;
        instr_err_o  = err_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog restarts on every state change so each handshake gets its own budget.
  always_comb begin
    tmo_d = '0;
    if (state_d == state_q && watched) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      cls_q    <= ClsNone;
      nwords_q <= 3'd0;
      k_q      <= 3'd0;
      op_q     <= 8'd0;
      modrm_q  <= 8'd0;
      ea_q     <= 20'd0;
      data_q   <= 16'd0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      nwords_q <= nwords_d;
      k_q      <= k_d;
      op_q     <= op_d;
      modrm_q  <= modrm_d;
      ea_q     <= ea_d;
      data_q   <= data_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_fpu_esc_sequencer.sv
// Randomized bench for fpu_esc_sequencer against an instruction-level reference model.
module tb_fpu_esc_sequencer;

  localparam int unsigned Tmo = 8;
  localparam int KNone = 0, KLoad = 1, KStore = 2, KAx = 3, KErr = 4;

  logic        clk, reset_n;
  logic        instr_valid;
  logic [7:0]  instr_opcode, instr_modrm;
  logic [19:0] instr_ea;
  logic        instr_ready_o, instr_done_o, instr_err_o, ax_we_o;
  logic [15:0] ax_data_o;
  logic        adp_escape_o, adp_wr_o, adp_rd_o;
  logic [7:0]  adp_opcode_o, adp_modrm_o;
  logic [15:0] adp_wdata_o;
  logic        adp_rvalid, adp_ready, mem_ack;
  logic [15:0] adp_rdata, mem_rdata;
  logic [19:0] mem_addr_o;
  logic        mem_rd_o, mem_wr_o;
  logic [15:0] mem_wdata_o;

  fpu_esc_sequencer #(
    .TIMEOUT_CYCLES (Tmo),
    .TMO_W          (10)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .instr_valid_i  (instr_valid),
    .instr_opcode_i (instr_opcode),
    .instr_modrm_i  (instr_modrm),
    .instr_ea_i     (instr_ea),
    .instr_ready_o  (instr_ready_o),
    .instr_done_o   (instr_done_o),
    .instr_err_o    (instr_err_o),
    .ax_we_o        (ax_we_o),
    .ax_data_o      (ax_data_o),
    .adp_escape_o   (adp_escape_o),
    .adp_opcode_o   (adp_opcode_o),
    .adp_modrm_o    (adp_modrm_o),
    .adp_wr_o       (adp_wr_o),
    .adp_wdata_o    (adp_wdata_o),
    .adp_rd_o       (adp_rd_o),
    .adp_rvalid_i   (adp_rvalid),
    .adp_rdata_i    (adp_rdata),
    .adp_ready_i    (adp_ready),
    .mem_addr_o     (mem_addr_o),
    .mem_rd_o       (mem_rd_o),
    .mem_wr_o       (mem_wr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata),
    .mem_ack_i      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_errors, cyc;
  int lat_cur, rdy_dly_cur, rdy_cnt, mem_wait, rv_wait;
  bit withhold_cur;
  logic [7:0] cur_op, cur_modrm;
  int esc_n, esc_cyc, done_cyc, rd_hi, wr_hi;
  bit done_seen, done_err;
  logic [19:0] rd_addr_q[$], mw_addr_q[$];
  logic [15:0] adp_wr_q[$], mw_data_q[$], ax_q[$], st_words[$], preset_q[$];
  logic [15:0] mem_m [logic [19:0]];

  // Instruction table: opcode, reg field (8 = any), kind, word count (memory forms only).
  int tbl[11][4] = '{
    '{'hD8, 8, KLoad, 2}, '{'hD9, 0, KLoad, 2}, '{'hD9, 5, KLoad, 1}, '{'hDD, 0, KLoad, 4},
    '{'hDB, 5, KLoad, 5}, '{'hD9, 2, KStore, 2}, '{'hD9, 7, KStore, 1}, '{'hDD, 2, KStore, 4},
    '{'hDD, 7, KStore, 1}, '{'hDB, 7, KStore, 5}, '{'hDF, 9, KNone, 0}
  };

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void spec_class(input logic [7:0] op, input logic [7:0] modrm,
                                     output int kind, output int n);
    kind = KNone;
    n    = 0;
    if (!((op >= 8'hD8 && op <= 8'hDF) || op == 8'h9B)) kind = KErr;
    else if (op == 8'hDF && modrm == 8'hE0) begin
      kind = KAx;
      n    = 1;
    end else if (modrm[7:6] != 2'b11) begin
      foreach (tbl[i]) begin
        if (tbl[i][0] == int'(op) && (tbl[i][1] == 8 || tbl[i][1] == int'(modrm[5:3]))) begin
          kind = tbl[i][2];
          n    = tbl[i][3];
        end
      end
    end
  endfunction

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a[15:0] ^ 16'h6C1B ^ {a[19:16], 12'h000};
  endfunction

  // One cycle: observe outputs at the falling edge, then drive responses for the next rise.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (instr_valid && !instr_ready_o) instr_valid = 1'b0;
    if (adp_escape_o) begin
      esc_n++;
      esc_cyc = cyc;
      check_eq("esc_opcode", adp_opcode_o, cur_op);
      check_eq("esc_modrm", adp_modrm_o, cur_modrm);
      rdy_cnt   = rdy_dly_cur;
      adp_ready = (rdy_cnt == 0);
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      adp_ready = (rdy_cnt == 0);
    end
    if (adp_wr_o) adp_wr_q.push_back(adp_wdata_o);
    if (ax_we_o) ax_q.push_back(ax_data_o);
    if (mem_rd_o) rd_hi++;
    if (mem_wr_o) wr_hi++;
    if (instr_done_o) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      done_err  = instr_err_o;
    end
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if ((mem_rd_o || mem_wr_o) && !withhold_cur) begin
      if (mem_wait >= lat_cur) begin
        mem_ack  = 1'b1;
        mem_wait = 0;
        if (mem_rd_o) begin
          mem_rdata = mem_word(mem_addr_o);
          rd_addr_q.push_back(mem_addr_o);
        end else begin
          mw_addr_q.push_back(mem_addr_o);
          mw_data_q.push_back(mem_wdata_o);
        end
      end else mem_wait++;
    end else mem_wait = 0;
    adp_rvalid = 1'b0;
    adp_rdata  = 16'($urandom);
    if (adp_rd_o) begin
      if (rv_wait >= lat_cur) begin
        adp_rvalid = 1'b1;
        adp_rdata  = (st_words.size() != 0) ? st_words.pop_front() : 16'hDEAD;
        rv_wait    = 0;
      end else rv_wait++;
    end else rv_wait = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] modrm, input logic [19:0] ea,
                       input int lat, input int rdy_dly, input bit withhold,
                       input int abort_reads, output bit aborted);
    int kind, n, start, spin, exp_rd, exp_mw;
    logic [15:0] exp_st[$];
    logic [19:0] a;
    logic [15:0] w;
    aborted = 1'b0;
    spec_class(op, modrm, kind, n);
    st_words.delete();
    for (int k = 0; k < n; k++) begin
      if (preset_q.size() != 0) w = preset_q.pop_front();
      else w = 16'($urandom);
      st_words.push_back(w);
    end
    exp_st = st_words;
    rd_addr_q.delete(); mw_addr_q.delete(); mw_data_q.delete(); adp_wr_q.delete(); ax_q.delete();
    esc_n = 0; rd_hi = 0; wr_hi = 0; mem_wait = 0; rv_wait = 0; rdy_cnt = 0;
    done_seen = 1'b0; done_err = 1'b0; esc_cyc = 0; done_cyc = 0;
    lat_cur = lat; rdy_dly_cur = rdy_dly; withhold_cur = withhold;
    cur_op = op; cur_modrm = modrm;
    spin = 0;
    while (!instr_ready_o && spin < 20) begin
      step();
      spin++;
    end
    instr_opcode = op; instr_modrm = modrm; instr_ea = ea; instr_valid = 1'b1;
    start = cyc;
    while (!done_seen && cyc - start < 300) begin
      step();
      if (abort_reads >= 0 && rd_addr_q.size() == abort_reads && mem_rd_o) begin
        aborted = 1'b1;
        return;
      end
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("err", done_err, (kind == KErr) || withhold);
    check_eq("esc_count", esc_n, (kind == KErr) ? 0 : 1);
    if (kind != KErr) check_eq("esc_lat", esc_cyc - start, 1);
    exp_rd = (kind == KLoad && !withhold) ? n : 0;
    check_eq("n_rd", rd_addr_q.size(), exp_rd);
    check_eq("n_adp_wr", adp_wr_q.size(), exp_rd);
    for (int k = 0; k < rd_addr_q.size() && k < adp_wr_q.size(); k++) begin
      a = ea + 20'(2 * k);
      check_eq("rd_addr", rd_addr_q[k], a);
      check_eq("adp_wdata", adp_wr_q[k], mem_word(a));
    end
    exp_mw = (kind == KStore) ? n : 0;
    check_eq("n_mem_wr", mw_addr_q.size(), exp_mw);
    for (int k = 0; k < mw_addr_q.size() && k < exp_st.size(); k++) begin
      a = ea + 20'(2 * k);
      check_eq("wr_addr", mw_addr_q[k], a);
      check_eq("wr_data", mw_data_q[k], exp_st[k]);
    end
    check_eq("n_ax", ax_q.size(), (kind == KAx) ? 1 : 0);
    if (kind == KAx && ax_q.size() != 0) check_eq("ax_data", ax_q[0], exp_st[0]);
    if (withhold) begin
      check_eq("tmo_rd_cycles", rd_hi, Tmo);
      check_eq("tmo_lat", done_cyc - start, Tmo + 3);
    end else if (kind == KNone) begin
      check_eq("wait_lat", done_cyc - start, 2 + ((rdy_dly > 1) ? rdy_dly : 1));
    end else if (kind == KErr) begin
      check_eq("err_lat", done_cyc - start, 1);
    end
    if (kind == KNone || kind == KAx || kind == KErr) check_eq("no_mem", rd_hi + wr_hi, 0);
    step();
    check_eq("ready_ret", instr_ready_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {instr_ready_o, instr_done_o, instr_err_o, ax_we_o, adp_escape_o, adp_wr_o,
                   adp_rd_o, mem_rd_o, mem_wr_o}, 9'b1_0000_0000);
    check_eq({tag, "_data"}, |{ax_data_o, adp_wdata_o, mem_wdata_o, mem_addr_o, adp_opcode_o,
                                adp_modrm_o}, 1'b0);
  endtask

  logic [7:0] dir_op[10] = '{8'hD8, 8'hD9, 8'hD9, 8'hDD, 8'hDB, 8'hD9, 8'hDD, 8'hDD, 8'hDB, 8'hDE};
  logic [7:0] dir_mr[10] = '{8'h45, 8'h2E, 8'h16, 8'h84, 8'h3E, 8'h7E, 8'h06, 8'h3C, 8'h2A, 8'h10};

  initial begin
    bit ab;
    logic [7:0] op, mr;
    logic [19:0] ea;
    int r;
    n_checks = 0; n_errors = 0; cyc = 0;
    instr_valid = 1'b0; instr_opcode = 8'h00; instr_modrm = 8'h00; instr_ea = 20'h0;
    adp_rvalid = 1'b0; adp_rdata = 16'h0; adp_ready = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
    rdy_cnt = 0; lat_cur = 0; rdy_dly_cur = 0; withhold_cur = 1'b0;
    mem_m[20'h01230] = 16'h0000;
    mem_m[20'h01232] = 16'h3F80;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    reset_n = 1'b1;

    issue(8'hD9, 8'h06, 20'h01230, 1, 2, 1'b0, -1, ab);
    preset_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    issue(8'hDD, 8'h16, 20'hFFFFC, 2, 0, 1'b0, -1, ab);
    preset_q = '{16'h3800};
    issue(8'hDF, 8'hE0, 20'h00100, 1, 1, 1'b0, -1, ab);
    issue(8'hD8, 8'hC1, 20'h00000, 0, 0, 1'b0, -1, ab);
    issue(8'h37, 8'h06, 20'h00000, 0, 0, 1'b0, -1, ab);
    issue(8'hDB, 8'h2E, 20'h12340, 0, 0, 1'b1, -1, ab);

    issue(8'hDB, 8'h2E, 20'h45670, 1, 0, 1'b0, 2, ab);
    check_eq("abort_reached", ab, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    instr_valid = 1'b0; mem_ack = 1'b0; adp_rvalid = 1'b0; adp_ready = 1'b1; rdy_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(8'h9B, 8'h00, 20'h00000, 0, 0, 1'b0, -1, ab);

    for (int i = 0; i < 10; i++) begin
      issue(dir_op[i], dir_mr[i], 20'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
            1'b0, -1, ab);
    end
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      op = 8'hD8 + 8'($urandom_range(0, 7));
      mr = 8'($urandom);
      if (r == 0) op = 8'($urandom);
      if (r == 1) op = 8'h9B;
      if (r == 2) begin
        op = 8'hDF;
        mr = 8'hE0;
      end
      ea = ($urandom_range(0, 1) == 1) ? (20'hFFFF0 | 20'($urandom_range(0, 15))) : 20'($urandom);
      issue(op, mr, ea, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, -1, ab);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
